// File: rtl/mbinit_sb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mbinit_sb_tx_arbiter
//   Shares the single sideband TX path between the MBINIT substate FSMs.
//   Round-robin arbitration picks one requester at a time. Its message is
//   strobed to the serializer, and the arbiter then follows the serializer
//   busy handshake (rise, then fall). When busy falls, the owner receives a
//   one-cycle done pulse. If busy never rises, the owner receives a
//   timeout-error pulse instead.
//
// Ports
//   CLK              clock
//   rst              synchronous reset, active-high
//   i_req_valid      per-requester level request, held until done/timeout
//   i_req_msg        message of requester k at [k*MSG_W +: MSG_W]
//   i_sb_busy        serializer busy
//   o_sb_valid       one-cycle send strobe to the serializer
//   o_sb_msg         latched message, held from ISSUE until back in IDLE
//   o_sb_src         granted requester index
//   o_grant          one-hot owner, high from ISSUE through WAIT_FALL
//   o_done           one-cycle pulse to the owner after busy falls
//   o_timeout_err    one-cycle pulse to the owner when busy never rose
//   o_busy_sideband  combinational: arbiter active or serializer busy
// -----------------------------------------------------------------------------
module mbinit_sb_tx_arbiter #(
    parameter  int N_REQ       = 4,
    parameter  int MSG_W       = 4,
    parameter  int TIMEOUT_CYC = 64,
    localparam int IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*MSG_W-1:0]   i_req_msg,
    input  logic                     i_sb_busy,
    output logic                     o_sb_valid,
    output logic [MSG_W-1:0]         o_sb_msg,
    output logic [IDW-1:0]           o_sb_src,
    output logic [N_REQ-1:0]         o_grant,
    output logic [N_REQ-1:0]         o_done,
    output logic [N_REQ-1:0]         o_timeout_err,
    output logic                     o_busy_sideband
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RISE = 2'd2,
        ST_WAIT_FALL = 2'd3
    } state_e;

    state_e             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sb_valid_q;
    logic [MSG_W-1:0]   msg_q;
    logic [IDW-1:0]     src_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   done_q;
    logic [N_REQ-1:0]   tmo_q;

    logic               hi_hit_s;
    logic [IDW-1:0]     hi_idx_s;
    logic [IDW-1:0]     lo_idx_s;
    logic [IDW-1:0]     pick_idx_s;
    logic [MSG_W-1:0]   pick_msg_s;
    logic [N_REQ-1:0]   pick_oh_s;
    logic [IDW-1:0]     rr_next_s;

    // Round-robin pick. Prefer the lowest valid index at or above rr_ptr. If
    // there is none, wrap to the lowest valid index overall. Scanning from the
    // top down lets the lowest match be written last and win.
    always_comb begin
        hi_hit_s = 1'b0;
        hi_idx_s = '0;
        lo_idx_s = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            lo_idx_s = i_req_valid[j] ? IDW'(j) : lo_idx_s;
            hi_idx_s = (i_req_valid[j] && (IDW'(j) >= rr_ptr_q)) ? IDW'(j) : hi_idx_s;
            hi_hit_s = hi_hit_s | (i_req_valid[j] && (IDW'(j) >= rr_ptr_q));
        end
        if (hi_hit_s) begin
            pick_idx_s = hi_idx_s;
        end else begin
            pick_idx_s = lo_idx_s;
        end
        pick_msg_s = '0;
        pick_oh_s  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pick_msg_s   = (IDW'(k) == pick_idx_s) ? i_req_msg[k*MSG_W +: MSG_W] : pick_msg_s;
            pick_oh_s[k] = (IDW'(k) == pick_idx_s);
        end
    end

    // Pointer value after the current owner releases the path: owner + 1, modulo N_REQ.
    always_comb begin
        if (src_q == IDW'(N_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = src_q + IDW'(1);
        end
    end

    // Arbiter FSM with registered outputs. Pulses default low every cycle.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            sb_valid_q <= 1'b0;
            msg_q      <= '0;
            src_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            tmo_q      <= '0;
        end else begin
            sb_valid_q <= 1'b0;
            done_q     <= '0;
            tmo_q      <= '0;
            case (state_q)
                ST_IDLE: begin
                    if ((|i_req_valid) && !i_sb_busy) begin
                        state_q    <= ST_ISSUE;
                        sb_valid_q <= 1'b1;
                        msg_q      <= pick_msg_s;
                        src_q      <= pick_idx_s;
                        grant_q    <= pick_oh_s;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT_RISE;
                    cnt_q   <= '0;
                end
                ST_WAIT_RISE: begin
                    // A busy rise takes priority over a timeout in the same cycle.
                    if (i_sb_busy) begin
                        state_q <= ST_WAIT_FALL;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_q  <= ST_IDLE;
                        tmo_q    <= grant_q;
                        rr_ptr_q <= rr_next_s;
                        grant_q  <= '0;
                        msg_q    <= '0;
                        src_q    <= '0;
                    end else if (cnt_q < CNT_W'(TIMEOUT_CYC - 1)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                ST_WAIT_FALL: begin
                    if (!i_sb_busy) begin
                        state_q  <= ST_IDLE;
                        done_q   <= grant_q;
                        rr_ptr_q <= rr_next_s;
                        grant_q  <= '0;
                        msg_q    <= '0;
                        src_q    <= '0;
                    end else begin
                        state_q <= ST_WAIT_FALL;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    msg_q   <= '0;
                    src_q   <= '0;
                end
            endcase
        end
    end

    assign o_sb_valid      = sb_valid_q;
    assign o_sb_msg        = msg_q;
    assign o_sb_src        = src_q;
    assign o_grant         = grant_q;
    assign o_done          = done_q;
    assign o_timeout_err   = tmo_q;
    assign o_busy_sideband = (state_q != ST_IDLE) | i_sb_busy;

endmodule

// File: tb/tb_mbinit_sb_tx_arbiter.sv
module tb_mbinit_sb_tx_arbiter;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] msgs;
    logic        busy;
    logic        o_sb_valid;
    logic [3:0]  o_sb_msg;
    logic [1:0]  o_sb_src;
    logic [3:0]  o_grant;
    logic [3:0]  o_done;
    logic [3:0]  o_timeout_err;
    logic        o_busy_sideband;

    always #5 CLK = ~CLK;

    mbinit_sb_tx_arbiter #(.N_REQ(N), .MSG_W(W), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .rst(rst), .i_req_valid(req), .i_req_msg(msgs), .i_sb_busy(busy),
        .o_sb_valid(o_sb_valid), .o_sb_msg(o_sb_msg), .o_sb_src(o_sb_src),
        .o_grant(o_grant), .o_done(o_done), .o_timeout_err(o_timeout_err),
        .o_busy_sideband(o_busy_sideband)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (transaction level) ----------------
    int         m_owner = -1;   // -1: path free
    int         m_ptr   = 0;    // where the next search starts
    int         m_wait  = 0;    // idle cycles spent waiting for busy to rise
    bit         m_sent  = 0;    // strobe cycle already elapsed
    bit         m_rose  = 0;    // busy has been seen high
    logic [3:0] m_msg   = '0;
    logic       e_valid = 0;
    logic [3:0] e_done  = '0;
    logic [3:0] e_tmo   = '0;

    function automatic void mdl_release();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
    endfunction

    function automatic void mdl_step();
        int c;
        e_valid = 0; e_done = '0; e_tmo = '0;
        if (rst) begin
            m_owner = -1; m_ptr = 0;
            return;
        end
        if (m_owner < 0) begin
            if (req != 4'd0 && !busy) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (m_owner < 0 && req[c]) m_owner = c;
                end
                m_msg = msgs[m_owner*W +: W];
                m_sent = 0; m_rose = 0; e_valid = 1;
            end
        end else if (!m_sent) begin
            m_sent = 1; m_wait = 0;
        end else if (!m_rose) begin
            if (busy) m_rose = 1;
            else if (m_wait == TO - 1) begin e_tmo[m_owner] = 1'b1; mdl_release(); end
            else m_wait++;
        end else if (!busy) begin
            e_done[m_owner] = 1'b1; mdl_release();
        end
    endfunction

    function automatic logic [3:0] exp_grant();
        logic [3:0] one4 = 4'b0001;
        return (m_owner >= 0) ? (one4 << m_owner) : 4'd0;
    endfunction

    // Event logs for order checks
    int grants_q[$];
    int gmsg_q[$];
    int dones_q[$];

    task automatic tick();
        @(posedge CLK);
        mdl_step();
        #1;
        cmp("sb_valid", o_sb_valid, e_valid);
        cmp("sb_msg",   o_sb_msg,   (m_owner >= 0) ? m_msg : 4'd0);
        cmp("sb_src",   o_sb_src,   (m_owner >= 0) ? 2'(m_owner) : 2'd0);
        cmp("grant",    o_grant,    exp_grant());
        cmp("done",     o_done,     e_done);
        cmp("timeout",  o_timeout_err, e_tmo);
        cmp("busy_sb",  o_busy_sideband, (m_owner >= 0) || busy);
        if (o_sb_valid) begin grants_q.push_back(int'(o_sb_src)); gmsg_q.push_back(int'(o_sb_msg)); end
        for (int k = 0; k < N; k++) if (o_done[k]) dones_q.push_back(k);
    endtask

    // ---------------- serializer emulation ----------------
    int ser_start = 0, ser_left = 0, ser_d = 0, ser_l = 1;

    task automatic ser_update();
        if (ser_left > 0) begin busy = 1'b1; ser_left--; end
        else if (ser_start > 0) begin
            ser_start--;
            if (ser_start == 0) begin busy = 1'b1; ser_left = ser_l - 1; end
            else busy = 1'b0;
        end else busy = 1'b0;
        if (o_sb_valid && ser_d > 0) ser_start = ser_d;
    endtask

    task automatic do_reset();
        rst = 1'b1; busy = 1'b0; req = '0; ser_start = 0; ser_left = 0;
        tick();
        rst = 1'b0;
        grants_q.delete(); gmsg_q.delete(); dones_q.delete();
    endtask

    task automatic run_traffic(input int cycles, input int d, input int l, input bit hold, input bit rnd);
        ser_d = d; ser_l = l;
        for (int c = 0; c < cycles; c++) begin
            tick();
            for (int k = 0; k < N; k++)
                if ((o_done[k] || o_timeout_err[k]) && !hold) req[k] = 1'b0;
            if (rnd) begin
                ser_d = $urandom_range(0, 4);
                ser_l = $urandom_range(1, 5);
            end
            ser_update();
            if (rnd) begin
                for (int k = 0; k < N; k++) begin
                    if (!req[k] && $urandom_range(0, 3) == 0) req[k] = 1'b1;
                    else if (req[k] && $urandom_range(0, 15) == 0) req[k] = 1'b0;
                end
                if ($urandom_range(0, 3) == 0) msgs = 16'($urandom);
                if (ser_left == 0 && ser_start == 0 && $urandom_range(0, 9) == 0) busy = 1'b1;
                rst = ($urandom_range(0, 99) == 0);
            end
        end
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r;
        logic [3:0]  rq;
        logic [15:0] m;
        logic        b;
        logic        ev;
        logic [3:0]  em;
        logic [1:0]  es;
        logic [3:0]  eg;
        logic [3:0]  ed;
        logic [3:0]  et;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(logic r, logic [3:0] rq, logic [15:0] m, logic b, logic ev,
                                logic [3:0] em, logic [1:0] es, logic [3:0] eg, logic [3:0] ed, logic [3:0] et);
        vec_t v;
        v.r = r; v.rq = rq; v.m = m; v.b = b; v.ev = ev; v.em = em; v.es = es; v.eg = eg; v.ed = ed; v.et = et;
        vecs.push_back(v);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v_at, t_at, d_cnt, nv;
        bit regrant;
        rst = 1'b1; req = '0; msgs = '0; busy = 1'b0;
        tick(); tick();
        cmp("rst_valid", o_sb_valid, 1'b0);
        cmp("rst_grant", o_grant, 4'd0);
        cmp("rst_done",  o_done, 4'd0);
        cmp("rst_tmo",   o_timeout_err, 4'd0);
        cmp("rst_msgsrc", {o_sb_msg, o_sb_src}, 6'd0);

        // Single request: strobe, busy rises 2 cycles later, stays 10, done after fall.
        // The requester changes its message after the grant; the latched one must remain.
        add(0, 4'b0001, 16'h0001, 0, 1, 4'h1, 2'd0, 4'b0001, 4'd0, 4'd0);
        add(0, 4'b0001, 16'h000F, 0, 0, 4'h1, 2'd0, 4'b0001, 4'd0, 4'd0);
        add(0, 4'b0001, 16'h000F, 0, 0, 4'h1, 2'd0, 4'b0001, 4'd0, 4'd0);
        for (int i = 0; i < 10; i++)
            add(0, 4'b0001, 16'h000F, 1, 0, 4'h1, 2'd0, 4'b0001, 4'd0, 4'd0);
        add(0, 4'b0001, 16'h000F, 0, 0, 4'h0, 2'd0, 4'b0000, 4'b0001, 4'd0);
        add(0, 4'b0000, 16'h000F, 0, 0, 4'h0, 2'd0, 4'b0000, 4'd0, 4'd0);
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].r; req = vecs[i].rq; msgs = vecs[i].m; busy = vecs[i].b;
            tick();
            cmp($sformatf("vec%0d_valid", i), o_sb_valid, vecs[i].ev);
            cmp($sformatf("vec%0d_msg", i),   o_sb_msg, vecs[i].em);
            cmp($sformatf("vec%0d_src", i),   o_sb_src, vecs[i].es);
            cmp($sformatf("vec%0d_grant", i), o_grant, vecs[i].eg);
            cmp($sformatf("vec%0d_done", i),  o_done, vecs[i].ed);
            cmp($sformatf("vec%0d_tmo", i),   o_timeout_err, vecs[i].et);
        end

        // Simultaneous requests from a fresh pointer: order 0,1,2,3.
        do_reset();
        msgs = 16'h8421; req = 4'b1111;
        run_traffic(40, 1, 3, 0, 0);
        cmp("simul_ngrant", grants_q.size(), 4);
        cmp("simul_ndone", dones_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < grants_q.size()) begin
                cmp($sformatf("simul_grant%0d", k), grants_q[k], k);
                cmp($sformatf("simul_msg%0d", k), gmsg_q[k], 1 << k);
            end
            if (k < dones_q.size()) cmp($sformatf("simul_done%0d", k), dones_q[k], k);
        end

        // Fairness: 0 and 2 held continuously.
        do_reset();
        req = 4'b0101;
        run_traffic(30, 1, 2, 1, 0);
        cmp("fair_enough", grants_q.size() >= 4, 1'b1);
        for (int k = 0; k < 4; k++)
            if (k < grants_q.size()) cmp($sformatf("fair_grant%0d", k), grants_q[k], (k % 2) * 2);

        // Timeout: busy never rises. TIMEOUT_CYC cycles are spent waiting, then the pulse.
        do_reset();
        req = 4'b0010;
        v_at = -1; t_at = -1; d_cnt = 0; regrant = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_done != 4'd0) d_cnt++;
            if (o_sb_valid && t_at >= 0) begin
                cmp("tmo_next_src", o_sb_src, 2'd2);
                regrant = 1;
                break;
            end
            if (o_sb_valid) v_at = i;
            if (o_timeout_err != 4'd0) begin
                t_at = i;
                cmp("tmo_vec", o_timeout_err, 4'b0010);
                cmp("tmo_idle", {o_grant, o_busy_sideband}, 5'd0);
                req = 4'b1101;
            end
        end
        cmp("tmo_latency", t_at - v_at, TO + 1);
        cmp("tmo_no_done", d_cnt, 0);
        cmp("tmo_regrant_seen", regrant, 1'b1);

        // Busy blocking: no strobe while busy is high; strobe the cycle after it drops.
        do_reset();
        busy = 1'b1; req = 4'b1000; msgs = 16'h9000;
        nv = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (o_sb_valid) nv++; end
        cmp("block_no_valid", nv, 0);
        busy = 1'b0;
        tick();
        cmp("block_valid", o_sb_valid, 1'b1);
        cmp("block_src", o_sb_src, 2'd3);
        cmp("block_msg", o_sb_msg, 4'h9);

        // Reset while in WAIT_FALL: no done pulse, pointer back to 0.
        do_reset();
        req = 4'b0100; msgs = 16'h0500;
        tick();
        cmp("wf_src", o_sb_src, 2'd2);
        tick();
        busy = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        cmp("wf_rst_outs", {o_sb_valid, o_sb_msg, o_sb_src, o_grant, o_done, o_timeout_err}, 19'd0);
        rst = 1'b0; busy = 1'b0; req = '0;
        d_cnt = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (o_done != 4'd0) d_cnt++; end
        cmp("wf_no_done", d_cnt, 0);
        req = 4'b0110;
        tick();
        cmp("wf_regrant_valid", o_sb_valid, 1'b1);
        cmp("wf_regrant_src", o_sb_src, 2'd1);

        // Randomized traffic against the reference model.
        do_reset();
        run_traffic(3000, 0, 1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
